pwm_audio_agc: RTL and testbench

//   Parametrised audio PWM output stage for the 1-bit AM receiver. Takes unsigned demodulated

---
 rtl/pwm_audio_agc.sv | 105 ++++++++++
 tb/tb_pwm_audio_agc.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_audio_agc.sv
// pwm_audio_agc: audio PWM output stage with shift gain (manual or AGC), saturation and boundary-latched duty
//   clk          system clock
//   RST          asynchronous reset, active high
//   sample_in    unsigned demodulated sample, valid with sample_tick
//   sample_tick  one-cycle strobe capturing sample_in
//   agc_en       1 = automatic gain, 0 = gain_man
//   gain_man     manual gain shift, clamped to SHIFT_MAX
//   pwm_out      registered PWM pin
//   gain_cur     gain shift currently applied
//   clip         one-cycle pulse when the latched duty saturated
//   period_start one-cycle pulse on the count==0 cycle
module pwm_audio_agc #(
  parameter int IN_W        = 16,
  parameter int PWM_BITS    = 8,
  parameter int SHIFT_MAX   = 7,
  parameter int HEADROOM    = 1,
  parameter int DECAY_SHIFT = 10,
  parameter int AGC_UPD     = 4,
  localparam int GW         = $clog2(SHIFT_MAX + 1)
) (
  input  logic            clk,
  input  logic            RST,
  input  logic [IN_W-1:0] sample_in,
  input  logic            sample_tick,
  input  logic            agc_en,
  input  logic [GW-1:0]   gain_man,
  output logic            pwm_out,
  output logic [GW-1:0]   gain_cur,
  output logic            clip,
  output logic            period_start
);
  localparam int UW = $clog2(AGC_UPD + 1);
  logic [PWM_BITS-1:0] r_count;
  logic [PWM_BITS-1:0] r_duty;
  logic [IN_W-1:0]     r_sample;
  logic [IN_W-1:0]     r_peak;
  logic [GW-1:0]       r_gain;
  logic [UW-1:0]       r_upd;
  logic                r_pwm;
  logic                r_clip;
  logic                r_ps;
  logic                w_wrap;
  logic [IN_W-1:0]     w_scaled;
  logic                w_sat;
  logic [PWM_BITS-1:0] w_duty_nxt;
  logic [GW-1:0]       w_gman;
  logic [GW-1:0]       w_tgt;
  logic                w_attack;
  logic                w_release;
  logic [GW-1:0]       w_gain_nxt;
  int                  w_lz;
  function automatic int lead_zeros(input logic [IN_W-1:0] v);
    lead_zeros = IN_W;
    for (int i = 0; i < IN_W; i++)
      if (v[i]) lead_zeros = IN_W - 1 - i;
  endfunction
  assign w_wrap     = &r_count;
  assign w_scaled   = r_sample << r_gain;
  // any bit shifted out of the top means the scaled sample no longer fits
  assign w_sat      = |(r_sample & ~({IN_W{1'b1}} >> r_gain));
  assign w_duty_nxt = w_sat ? '1 : w_scaled[IN_W-1 -: PWM_BITS];
  assign w_gman     = (int'(gain_man) > SHIFT_MAX) ? GW'(SHIFT_MAX) : gain_man;
  assign w_lz       = lead_zeros(r_peak);
  always_comb begin
    w_tgt = '0;
    if (w_lz - HEADROOM > SHIFT_MAX) w_tgt = GW'(SHIFT_MAX);
    else if (w_lz > HEADROOM) w_tgt = GW'(w_lz - HEADROOM);
  end
  assign w_attack   = agc_en & (w_tgt < r_gain);
  assign w_release  = agc_en & (w_tgt > r_gain) & (int'(r_upd) >= AGC_UPD);
  assign w_gain_nxt = !agc_en ? w_gman : w_attack ? w_tgt : w_release ? r_gain + 1'b1 : r_gain;
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_count  <= '0;
      r_duty   <= '0;
      r_sample <= '0;
      r_peak   <= '0;
      r_gain   <= '0;
      r_upd    <= '0;
      r_pwm    <= 1'b0;
      r_clip   <= 1'b0;
      r_ps     <= 1'b0;
    end else begin
      r_count <= r_count + 1'b1;
      r_pwm   <= r_count < r_duty;
      r_ps    <= w_wrap;
      r_clip  <= w_wrap & w_sat;
      if (sample_tick) begin
        r_sample <= sample_in;
        r_peak   <= (sample_in > r_peak) ? sample_in : r_peak - (r_peak >> DECAY_SHIFT);
      end
      if (w_wrap) begin
        r_duty <= w_duty_nxt;
        r_gain <= w_gain_nxt;
      end
      // a gain step at the wrap restarts the release hold-off, overriding this cycle's tick
      r_upd <= (w_wrap & (w_attack | w_release)) ? '0 :
               (sample_tick && int'(r_upd) < AGC_UPD) ? r_upd + 1'b1 : r_upd;
    end
  end
  assign pwm_out      = r_pwm;
  assign gain_cur     = r_gain;
  assign clip         = r_clip;
  assign period_start = r_ps;
endmodule

// File: tb/tb_pwm_audio_agc.sv
// tb_pwm_audio_agc: table vectors, corner sequences and randomized run against a behavioural model
module tb_pwm_audio_agc;
  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] sample_in;
  logic        sample_tick;
  logic        agc_en;
  logic [2:0]  gain_man;
  logic        pwm_out;
  logic [2:0]  gain_cur;
  logic        clip;
  logic        period_start;
  int checks = 0;
  int errors = 0;
  int m_cnt = 0, m_samp = 0, m_peak = 0, m_gain = 0, m_duty = 0, m_upd = 0;
  int m_pwm = 0, m_clip = 0, m_ps = 0;
  typedef struct {int g; int s; int d; int c;} vec_t;
  vec_t tbl[8];
  always #5 clk = ~clk;
  pwm_audio_agc dut (
    .clk(clk), .RST(RST), .sample_in(sample_in), .sample_tick(sample_tick),
    .agc_en(agc_en), .gain_man(gain_man), .pwm_out(pwm_out), .gain_cur(gain_cur),
    .clip(clip), .period_start(period_start)
  );
  function automatic int lz16(input int v);
    for (int b = 15; b >= 0; b--)
      if (v >= (1 << b)) return 15 - b;
    return 16;
  endfunction
  function automatic int target(input int p);
    int t;
    t = lz16(p) - 1;
    if (t < 0) t = 0;
    if (t > 7) t = 7;
    return t;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  task automatic model_update();
    int sc, t, ng, u0;
    bit wrap, sat;
    if (RST) begin
      m_cnt = 0; m_samp = 0; m_peak = 0; m_gain = 0; m_duty = 0; m_upd = 0;
      m_pwm = 0; m_clip = 0; m_ps = 0;
      return;
    end
    wrap = (m_cnt == 255);
    sc   = m_samp << m_gain;
    sat  = sc > 65535;
    t    = target(m_peak);
    u0   = m_upd;
    m_pwm  = (m_cnt < m_duty);
    m_ps   = wrap;
    m_clip = wrap && sat;
    if (sample_tick && m_upd < 4) m_upd = m_upd + 1;
    if (wrap) begin
      m_duty = sat ? 255 : (sc >> 8) & 255;
      ng = m_gain;
      if (!agc_en) ng = (gain_man > 7) ? 7 : int'(gain_man);
      else if (t < m_gain) begin ng = t; m_upd = 0; end
      else if (t > m_gain && u0 >= 4) begin ng = m_gain + 1; m_upd = 0; end
      m_gain = ng;
    end
    if (sample_tick) begin
      m_peak = (int'(sample_in) > m_peak) ? int'(sample_in) : m_peak - (m_peak >> 10);
      m_samp = int'(sample_in);
    end
    m_cnt = (m_cnt + 1) % 256;
  endtask
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("pwm_out", pwm_out, m_pwm);
    chk("gain_cur", gain_cur, m_gain);
    chk("clip", clip, m_clip);
    chk("period_start", period_start, m_ps);
  endtask
  task automatic do_tick(input int v);
    sample_in = v[15:0];
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask
  task automatic wait_ps(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < 600);
    if (!period_start) chk("ps_timeout", period_start, 1);
  endtask
  task automatic measure(output int hi, output int cl);
    hi = int'(pwm_out);
    cl = int'(clip);
    repeat (255) begin
      step();
      hi += int'(pwm_out);
      cl += int'(clip);
    end
  endtask
  initial begin
    int n, hi, cl;
    tbl[0] = '{3, 'h1234, 'h91, 0};
    tbl[1] = '{3, 'h4000, 'hFF, 1};
    tbl[2] = '{0, 'h8000, 'h80, 0};
    tbl[3] = '{0, 'h00FF, 'h00, 0};
    tbl[4] = '{7, 'h01FF, 'hFF, 0};
    tbl[5] = '{7, 'h0200, 'hFF, 1};
    tbl[6] = '{4, 'h0ABC, 'hAB, 0};
    tbl[7] = '{1, 'hFFFF, 'hFF, 1};
    RST = 1'b1; sample_in = '0; sample_tick = 1'b0; agc_en = 1'b0; gain_man = '0;
    step();
    step();
    chk("rst_pwm", pwm_out, 0);
    chk("rst_gain", gain_cur, 0);
    chk("rst_clip", clip, 0);
    chk("rst_ps", period_start, 0);
    RST = 1'b0;
    foreach (tbl[i]) begin
      gain_man = tbl[i].g[2:0];
      do_tick(tbl[i].s);
      wait_ps(n);
      wait_ps(n);
      chk("ps_period", n, 256);
      measure(hi, cl);
      chk("tbl_duty", hi, tbl[i].d);
      chk("tbl_clip", cl, tbl[i].c);
      chk("tbl_gain", gain_cur, tbl[i].g);
    end
    gain_man = 3'd0;
    do_tick('h8000);
    wait_ps(n);
    repeat (255) step();
    sample_in = 16'h4000;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("wrap_tick_ps", period_start, 1);
    measure(hi, cl);
    chk("wrap_tick_old", hi, 'h80);
    wait_ps(n);
    measure(hi, cl);
    chk("wrap_tick_new", hi, 'h40);
    gain_man = 3'd1;
    do_tick('h4000);
    wait_ps(n);
    wait_ps(n);
    repeat (10) step();
    chk("pre_rst_pwm", pwm_out, 1);
    chk("pre_rst_gain", gain_cur, 1);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_pwm", pwm_out, 0);
    chk("async_rst_gain", gain_cur, 0);
    chk("async_rst_ps", period_start, 0);
    step();
    step();
    RST = 1'b0;
    hi = 0;
    repeat (256) begin
      step();
      hi += int'(pwm_out);
    end
    chk("post_rst_low", hi, 0);
    agc_en = 1'b1;
    repeat (60) begin
      do_tick('h0100);
      repeat (63) step();
    end
    chk("agc_settle", gain_cur, 6);
    wait_ps(n);
    repeat (5) step();
    do_tick('hF000);
    wait_ps(n);
    chk("agc_attack", gain_cur, 0);
    repeat (2000) begin
      do_tick(0);
      step();
    end
    chk("decay_rise", gain_cur >= 3'd1, 1);
    agc_en = 1'b0;
    gain_man = 3'd7;
    wait_ps(n);
    chk("man_switch", gain_cur, 7);
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) begin
        agc_en = 1'($urandom_range(0, 1));
        gain_man = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 3) == 0) do_tick($urandom_range(0, 65535) >> $urandom_range(0, 15));
      else step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
